// File: rtl/universal_shift_reg.sv
// WIDTH-bit storage/serialising register: gated single-step ops (1-edge latency) plus a burst engine.
// While a burst runs or its done cycle is shown, G/mode/D/start/count are ignored; busy/done report progress.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             G,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_R,
    input  logic             SI_L,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn_t,
    output logic             SO_L,
    output logic             SO_R,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [2:0]       bmode_q;
    logic [2:0]       op_sel;
    logic [CNT_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             burst_req;

    // Only the shift/rotate family can be repeated as a burst; hold/load/clear stay single-step.
    assign burst_req = start && (mode != OP_HOLD) && (mode != OP_LOAD) && (mode != OP_CLEAR);
    assign op_sel    = (state_q == ST_RUN) ? bmode_q : mode;

    always_comb begin
        q_d = q_q;
        case (op_sel)
            OP_HOLD:  q_d = q_q;
            OP_LOAD:  q_d = D;
            OP_SHL:   q_d = {q_q[WIDTH-2:0], SI_R};
            OP_SHR:   q_d = {SI_L, q_q[WIDTH-1:1]};
            OP_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            OP_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            OP_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            OP_CLEAR: q_d = '0;
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            bmode_q <= OP_HOLD;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (G) begin
                        if (burst_req) begin
                            // Accept edge: capture the burst, register stays put.
                            bmode_q <= mode;
                            if (count == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_RUN;
                                rem_q   <= count;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            q_q <= q_d;
                        end
                    end
                end
                ST_RUN: begin
                    q_q   <= q_d;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign Qn_t = ~q_q;
    assign SO_L = q_q[WIDTH-1];
    assign SO_R = q_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, CNT_W=4): single-step ops, bursts, reset abort.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       G;
    logic [2:0] mode;
    logic [7:0] D;
    logic       SI_R;
    logic       SI_L;
    logic       start;
    logic [3:0] count;
    logic [7:0] Q;
    logic [7:0] Qn_t;
    logic       SO_L;
    logic       SO_R;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .G     (G),
        .mode  (mode),
        .D     (D),
        .SI_R  (SI_R),
        .SI_L  (SI_L),
        .start (start),
        .count (count),
        .Q     (Q),
        .Qn_t  (Qn_t),
        .SO_L  (SO_L),
        .SO_R  (SO_R),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; G = 1'b1; mode = 3'b001; D = 8'hFF;
        SI_R = 1'b0; SI_L = 1'b0; start = 1'b0; count = 4'd0;
        tick();
        chk("reset_q",    32'(Q),    32'h00);
        chk("reset_qn",   32'(Qn_t), 32'hFF);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);

        // Single-step ops
        rst = 1'b0; mode = 3'b001; D = 8'hA5;
        tick(); chk("load_a5", 32'(Q), 32'hA5);
        chk("so_l", 32'(SO_L), 32'h1);
        chk("so_r", 32'(SO_R), 32'h1);
        mode = 3'b010; SI_R = 1'b1;
        tick(); chk("shl", 32'(Q), 32'h4B);
        mode = 3'b011; SI_L = 1'b0;
        tick(); chk("shr", 32'(Q), 32'h25);
        mode = 3'b001; D = 8'h80;
        tick(); chk("load_80", 32'(Q), 32'h80);
        mode = 3'b110;
        tick(); chk("asr", 32'(Q), 32'hC0);
        mode = 3'b101;
        tick(); chk("ror", 32'(Q), 32'h60);
        mode = 3'b100;
        tick(); chk("rol", 32'(Q), 32'hC0);
        G = 1'b0; mode = 3'b111;
        tick(); chk("gate_off_clear", 32'(Q), 32'hC0);
        start = 1'b1; mode = 3'b100; count = 4'd3;
        tick(); chk("gate_off_start_busy", 32'(busy), 32'h0);
        chk("gate_off_start_q", 32'(Q), 32'hC0);
        G = 1'b1; start = 1'b1; mode = 3'b001; D = 8'h3C;
        tick(); chk("start_load_q", 32'(Q), 32'h3C);
        chk("start_load_busy", 32'(busy), 32'h0);
        start = 1'b0; mode = 3'b111;
        tick(); chk("clear", 32'(Q), 32'h00);

        // Burst rol x3
        mode = 3'b001; D = 8'h81;
        tick();
        mode = 3'b100; count = 4'd3; start = 1'b1;
        tick(); chk("rol_accept_q", 32'(Q), 32'h81);
        chk("rol_accept_busy", 32'(busy), 32'h1);
        start = 1'b0; mode = 3'b000;
        tick(); chk("rol_e1", 32'(Q), 32'h03);
        chk("rol_e1_busy", 32'(busy), 32'h1);
        start = 1'b1; mode = 3'b001; D = 8'hFF;
        tick(); chk("rol_e2", 32'(Q), 32'h06);
        chk("rol_e2_busy", 32'(busy), 32'h1);
        chk("rol_e2_done", 32'(done), 32'h0);
        tick(); chk("rol_e3", 32'(Q), 32'h0C);
        chk("rol_e3_busy", 32'(busy), 32'h0);
        chk("rol_e3_done", 32'(done), 32'h1);
        tick(); chk("rol_e4_q", 32'(Q), 32'h0C);
        chk("rol_e4_done", 32'(done), 32'h0);
        chk("rol_e4_busy", 32'(busy), 32'h0);
        start = 1'b0;

        // Burst with count=0
        mode = 3'b001; D = 8'h5A;
        tick();
        mode = 3'b011; count = 4'd0; start = 1'b1;
        tick(); chk("cnt0_q", 32'(Q), 32'h5A);
        chk("cnt0_busy", 32'(busy), 32'h0);
        chk("cnt0_done", 32'(done), 32'h1);
        start = 1'b0; G = 1'b0;
        tick(); chk("cnt0_after_done", 32'(done), 32'h0);
        chk("cnt0_after_q", 32'(Q), 32'h5A);

        // Burst shr x8 with toggling serial input
        G = 1'b1; mode = 3'b001; D = 8'hFF;
        tick();
        mode = 3'b011; count = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            SI_L = (i % 2 == 0);
            tick();
            if (i == 6) chk("shr8_busy_mid", 32'(busy), 32'h1);
        end
        chk("shr8_q", 32'(Q), 32'h55);
        chk("shr8_done", 32'(done), 32'h1);
        chk("shr8_busy", 32'(busy), 32'h0);
        tick();

        // Reset during a burst
        mode = 3'b001; D = 8'h0F;
        tick();
        mode = 3'b010; count = 4'd5; start = 1'b1; SI_R = 1'b1;
        tick();
        start = 1'b0;
        tick(); chk("rst_step1", 32'(Q), 32'h1F);
        rst = 1'b1;
        tick(); chk("rst_mid_q", 32'(Q), 32'h00);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        rst = 1'b0; start = 1'b1; mode = 3'b100; count = 4'd2;
        tick(); chk("restart_busy", 32'(busy), 32'h1);
        chk("restart_done", 32'(done), 32'h0);
        start = 1'b0;
        tick();
        tick(); chk("restart_fin_done", 32'(done), 32'h1);
        chk("restart_fin_q", 32'(Q), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
